// File: rtl/fa_bl_top.sv
// Full adder with qualified, saturating carry-event counter and async reset.
// Define FA_BL_REG_OUT_EN to register carry/sum/out_valid (1-cycle latency).
module fa_bl_top #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ip1,
   input  logic             ip2,
   input  logic             ip3,
   input  logic             in_valid,
   input  logic             clr_cnt,
   output logic             carry,
   output logic             sum,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
);

   logic             carry_c;
   logic             sum_c;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign sum_c   = ip1 ^ ip2 ^ ip3;
   assign carry_c = (ip1 & ip2) | (ip1 & ip3) | (ip2 & ip3);

   // Clear wins over increment; an all-ones count is held rather than wrapped.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (in_valid && carry_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign carry_cnt = cnt_q;

`ifdef FA_BL_REG_OUT_EN
   logic carry_q;
   logic sum_q;
   logic vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q <= 1'b0;
         sum_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         carry_q <= carry_c;
         sum_q   <= sum_c;
         vld_q   <= in_valid;
      end
   end

   assign carry     = carry_q;
   assign sum       = sum_q;
   assign out_valid = vld_q;
`else
   // Data path stays live through reset; only the valid flag is forced low.
   assign carry     = carry_c;
   assign sum       = sum_c;
   assign out_valid = in_valid & ~rst;
`endif

endmodule

// File: tb/tb_fa_bl_top.sv
// Self-checking bench for fa_bl_top: directed truth-table/counter/reset cases
// plus randomized vectors against an arithmetic reference model.
module tb_fa_bl_top;

   logic       clk = 1'b0;
   logic       rst;
   logic       ip1, ip2, ip3, in_valid, clr_cnt;
   logic       carry, sum, out_valid;
   logic [7:0] cnt8;
   logic       carry2, sum2, out_valid2;
   logic [1:0] cnt2;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: counts as plain integers, previous vector for registered mode.
   int m_cnt8 = 0;
   int m_cnt2 = 0;
   bit p_c = 1'b0, p_s = 1'b0, p_v = 1'b0;

   fa_bl_top #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .ip1(ip1), .ip2(ip2), .ip3(ip3),
      .in_valid(in_valid), .clr_cnt(clr_cnt),
      .carry(carry), .sum(sum), .out_valid(out_valid), .carry_cnt(cnt8)
   );

   fa_bl_top #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .ip1(ip1), .ip2(ip2), .ip3(ip3),
      .in_valid(in_valid), .clr_cnt(clr_cnt),
      .carry(carry2), .sum(sum2), .out_valid(out_valid2), .carry_cnt(cnt2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called 1 time unit after a rising edge; checks mid-cycle, then advances one edge.
   task automatic step(input bit a, input bit b, input bit c, input bit v, input bit cl);
      int tot;
      bit ec, es;
      ip1 = a; ip2 = b; ip3 = c; in_valid = v; clr_cnt = cl;
      tot = int'(a) + int'(b) + int'(c);
      ec  = (tot >= 2);
      es  = (tot % 2) == 1;
      #4;
`ifdef FA_BL_REG_OUT_EN
      chk("carry", carry, p_c);
      chk("sum", sum, p_s);
      chk("out_valid", out_valid, p_v);
`else
      chk("carry", carry, ec);
      chk("sum", sum, es);
      chk("out_valid", out_valid, v);
`endif
      chk("cnt8", cnt8, m_cnt8);
      chk("cnt2", cnt2, m_cnt2);
      @(posedge clk);
      if (cl) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else if (v && ec) begin
         m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
         m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      p_c = ec; p_s = es; p_v = v;
      #1;
   endtask

   initial begin
      logic [2:0] tv;
      rst = 1'b1;
      ip1 = 1'b0; ip2 = 1'b0; ip3 = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
      #2;
      chk("rst_cnt8", cnt8, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_carry", carry, 0);
      chk("rst_sum", sum, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Exhaustive truth table, qualified
      for (int i = 0; i < 8; i++) begin
         tv = 3'(i);
         step(tv[2], tv[1], tv[0], 1'b1, 1'b0);
      end
      chk("cnt_after_tt", cnt8, 4);
      // Same table unqualified: count must not move
      for (int i = 0; i < 8; i++) begin
         tv = 3'(i);
         step(tv[2], tv[1], tv[0], 1'b0, 1'b0);
      end
      chk("cnt_hold_invalid", cnt8, 4);

      // Saturation on the 2-bit counter
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("sat_cnt2", cnt2, 3);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("sat_hold_cnt2", cnt2, 3);

      // Clear priority over simultaneous increment
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("clr_pre_cnt8", cnt8, 2);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_priority", cnt8, 0);

      // Async reset between edges with count at 3
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("pre_rst_cnt8", cnt8, 3);
      #2 rst = 1'b1;
      #1;
      chk("async_cnt8", cnt8, 0);
      chk("async_out_valid", out_valid, 0);
`ifdef FA_BL_REG_OUT_EN
      chk("async_carry", carry, 0);
      chk("async_sum", sum, 0);
`else
      chk("async_carry_follow", carry, 1);
      chk("async_sum_follow", sum, 1);
`endif
      m_cnt8 = 0; m_cnt2 = 0;
      p_c = 1'b0; p_s = 1'b0; p_v = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Release: qualified 110
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("release_cnt8", cnt8, 1);

      // Randomized vectors
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(3, 0) != 0), ($urandom_range(19, 0) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
